// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the four-digit seven-segment scan driver.
//   NUM_DIGITS      - digits on the display
//   GLYPH[0..15]    - hex segment shapes, bit 6 = a ... bit 0 = g
//   DASH / BLANK    - overflow marker and dark digit
//   conv_state_t    - sequential binary-to-BCD converter states
//   dd_adjust()     - double-dabble add-3 step over all five BCD digits
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,   // 0 1 2 3
        7'h33, 7'h5B, 7'h5F, 7'h70,   // 4 5 6 7
        7'h7F, 7'h7B, 7'h77, 7'h1F,   // 8 9 A b
        7'h4E, 7'h3D, 7'h4F, 7'h47    // C d E F
    };

    localparam logic [6:0] DASH  = 7'b0000001;
    localparam logic [6:0] BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // Add 3 to every BCD digit that is 5 or more, so the following shift
    // carries correctly into the next decade.
    function automatic logic [19:0] dd_adjust(input logic [19:0] acc);
        logic [19:0] r;
        r = acc;
        for (int i = 0; i < 5; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// bin2bcd_seq: sequential 16-bit binary to 5-digit BCD converter
// (double dabble, one bit per cycle).
//   clk, rst   - system clock, asynchronous active-high reset
//   bin        - value to convert, sampled on the cycle start is seen in IDLE
//   start      - conversion request, ignored unless IDLE
//   done       - high for the single DONE cycle; bcd is valid then
//   bcd        - five BCD digits, bcd[3:0] least significant
// IDLE -> SHIFT (16 cycles) -> DONE (1 cycle) -> IDLE.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bin,
    input  logic        start,
    output logic        done,
    output logic [19:0] bcd
);

    conv_state_t state, state_nx;
    logic [15:0] sh, sh_nx;
    logic [19:0] acc, acc_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [19:0] adj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sh    <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sh    <= sh_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        acc_nx   = acc;
        cnt_nx   = cnt;
        adj      = dd_adjust(acc);
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    sh_nx    = bin;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A 16-bit input never reaches bit 19 of the adjusted
                // accumulator, so dropping adj[19] loses nothing.
                acc_nx = {adj[18:0], sh[15]};
                sh_nx  = {sh[14:0], 1'b0};
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'd15) state_nx = ST_DONE;
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign done = (state == ST_DONE);
    assign bcd  = acc;

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed four-digit seven-segment driver.
//   clk, rst       - system clock, asynchronous active-high reset
//   value          - 16-bit number, snapshotted once per scan frame
//   blank_en       - suppress leading zeros (digit 0 always shown)
//   dp             - per-digit decimal point
//   digital_light  - registered segments {a,b,c,d,e,f,g,dp}, active-high
//   seg_en         - registered one-hot digit enable, [0] = rightmost
// Build option SEG_DECIMAL_EN: decimal 0-9999 display through bin2bcd_seq,
// dashes on overflow. Without it the display is plain 4-digit hex.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        blank_en,
    input  logic [3:0]  dp,
    output logic [7:0]  digital_light,
    output logic [3:0]  seg_en
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0]                 div_cnt;
    logic [1:0]                       idx;
    logic                             run;       // low only until the first cycle after reset
    logic [15:0]                      snap;
    logic [NUM_DIGITS-1:0][3:0]       disp;
    logic                             upd_pend;  // one cycle after frame start
    logic                             disp_ovf;
    logic                             div_tc;
    logic                             frame_start;
    logic [NUM_DIGITS-1:0]            lead_zero;
    logic [6:0]                       seg_nx;

    assign div_tc      = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_start = !run || (div_tc && idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            idx      <= '0;
            run      <= 1'b0;
            snap     <= '0;
            upd_pend <= 1'b0;
        end else begin
            run <= 1'b1;
            if (div_tc) begin
                div_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (frame_start) snap <= value;
            upd_pend <= frame_start;
        end
    end

`ifdef SEG_DECIMAL_EN
    logic        conv_done;
    logic [19:0] bcd;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .bin   (snap),
        .start (upd_pend),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // A non-zero ten-thousands digit is exactly snap > 9999.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp     <= '0;
            disp_ovf <= 1'b0;
        end else if (conv_done) begin
            disp     <= bcd[15:0];
            disp_ovf <= (bcd[19:16] != 4'd0);
        end
    end
`else
    assign disp_ovf = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           disp <= '0;
        else if (upd_pend) disp <= snap;
    end
`endif

    // Digit i >= 1 is a leading zero when it and every higher digit is 0.
    always_comb begin
        lead_zero    = '0;
        lead_zero[3] = (disp[3] == 4'd0);
        lead_zero[2] = lead_zero[3] && (disp[2] == 4'd0);
        lead_zero[1] = lead_zero[2] && (disp[1] == 4'd0);
        lead_zero[0] = 1'b0;
    end

    always_comb begin
        seg_nx = GLYPH[disp[idx]];
        if (disp_ovf)                          seg_nx = DASH;
        else if (blank_en && lead_zero[idx])   seg_nx = BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_en        <= '0;
            digital_light <= '0;
        end else begin
            seg_en        <= 4'b0001 << idx;
            digital_light <= {seg_nx, dp[idx]};
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed bench for seg_scan_display with SCAN_DIV=32.
// Expected digit glyphs are queued when a value is driven and checked as the
// scan reaches each digit. Decimal tests run when SEG_DECIMAL_EN is defined.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        blank_en = 1'b0;
    logic [3:0]  dp = '0;
    logic [7:0]  digital_light;
    logic [3:0]  seg_en;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [3:0] seg;
        logic [7:0] light;
    } exp_t;

    exp_t sb[$];

`ifdef SEG_DECIMAL_EN
    localparam logic [15:0] V_FIRST = 16'd1234;
    localparam logic [15:0] V_1111  = 16'd1111;
    localparam logic [15:0] V_2222  = 16'd2222;
    localparam logic [15:0] V_4321  = 16'd4321;
`else
    localparam logic [15:0] V_FIRST = 16'h1A3F;
    localparam logic [15:0] V_1111  = 16'h1111;
    localparam logic [15:0] V_2222  = 16'h2222;
    localparam logic [15:0] V_4321  = 16'h4321;
`endif

    seg_scan_display #(.SCAN_DIV(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .value         (value),
        .blank_en      (blank_en),
        .dp            (dp),
        .digital_light (digital_light),
        .seg_en        (seg_en)
    );

    always #5 clk = ~clk;

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: seg_en=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: digital_light=%h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until seg_en equals / differs from tgt.
    task automatic wait_seg(input string tag, input logic [3:0] tgt, input bit eq, output bit ok);
        int n;
        n = 0;
        while (((seg_en === tgt) != eq) && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = ((seg_en === tgt) == eq);
        if (!ok) begin
            total++;
            bad++;
            $error("FAIL %s: timeout, seg_en=%b waiting on %b", tag, seg_en, tgt);
        end
    endtask

    task automatic next_frame();
        bit ok;
        wait_seg("frame_in", 4'b1000, 1'b1, ok);
        wait_seg("frame_out", 4'b1000, 1'b0, ok);
    endtask

    task automatic push_frame(input string tag, input logic [7:0] l0, input logic [7:0] l1,
                              input logic [7:0] l2, input logic [7:0] l3);
        sb.push_back('{{tag, "_d0"}, 4'b0001, l0});
        sb.push_back('{{tag, "_d1"}, 4'b0010, l1});
        sb.push_back('{{tag, "_d2"}, 4'b0100, l2});
        sb.push_back('{{tag, "_d3"}, 4'b1000, l3});
    endtask

    // Pop each expectation, sample 24 cycles into its digit slot (past the
    // decimal conversion latency), then move past that slot.
    task automatic drain();
        exp_t e;
        bit   ok;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_seg(e.tag, e.seg, 1'b1, ok);
            if (ok) begin
                repeat (24) @(negedge clk);
                chk8(e.tag, digital_light, e.light);
                wait_seg(e.tag, e.seg, 1'b0, ok);
            end
        end
    endtask

    initial begin
        value = V_FIRST;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        chk4("rst_seg", seg_en, 4'b0000);
        chk8("rst_light", digital_light, 8'h00);
        rst = 1'b0;

        // Scan sequencing: digit 0 on the first edge, then every 32 cycles.
        @(posedge clk); #1;
        chk4("scan_e1", seg_en, 4'b0001);
        chk8("scan_e1_light", digital_light, 8'hFC);
        repeat (31) @(posedge clk); #1;
        chk4("scan_e32", seg_en, 4'b0001);
        @(posedge clk); #1;
        chk4("scan_e33", seg_en, 4'b0010);
        repeat (32) @(posedge clk); #1;
        chk4("scan_e65", seg_en, 4'b0100);
        repeat (32) @(posedge clk); #1;
        chk4("scan_e97", seg_en, 4'b1000);
        repeat (32) @(posedge clk); #1;
        chk4("scan_e129", seg_en, 4'b0001);

`ifdef SEG_DECIMAL_EN
        push_frame("dec1234", 8'h66, 8'hF2, 8'hDA, 8'h60);
        drain();
        value = 16'd12345;
        next_frame();
        push_frame("ovf12345", 8'h02, 8'h02, 8'h02, 8'h02);
        drain();
        value    = 16'd10000;
        blank_en = 1'b1;
        next_frame();
        push_frame("ovf_blank", 8'h02, 8'h02, 8'h02, 8'h02);
        drain();
`else
        push_frame("hex1A3F", 8'h8E, 8'hF2, 8'hEE, 8'h60);
        drain();
`endif

        blank_en = 1'b1;
        dp       = 4'b0100;
        value    = 16'd7;
        next_frame();
        push_frame("blank7", 8'hE0, 8'h00, 8'h01, 8'h00);
        drain();
        value = 16'd0;
        next_frame();
        push_frame("blank0", 8'hFC, 8'h00, 8'h01, 8'h00);
        drain();

        // Mid-frame value change is held off until the next frame.
        blank_en = 1'b0;
        dp       = 4'b0000;
        value    = V_1111;
        next_frame();
        push_frame("ones", 8'h60, 8'h60, 8'h60, 8'h60);
        drain();
        begin
            bit ok;
            wait_seg("mid_wait", 4'b0100, 1'b1, ok);
        end
        value = V_2222;
        sb.push_back('{"mid_old_d2", 4'b0100, 8'h60});
        sb.push_back('{"mid_old_d3", 4'b1000, 8'h60});
        drain();
        push_frame("twos", 8'hDA, 8'hDA, 8'hDA, 8'hDA);
        drain();

        // Reset a few cycles into a frame update (mid-conversion in decimal).
        next_frame();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk4("midrst_seg", seg_en, 4'b0000);
        chk8("midrst_light", digital_light, 8'h00);
        value = V_4321;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push_frame("after_rst", 8'h60, 8'hDA, 8'hF2, 8'h66);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Time-multiplexed driver for the board's four-digit seven-segment display. Snapshots a 16-bit value once per scan frame, optionally converts it to decimal with a sequential binary-to-BCD converter, and drives one digit at a time through `digital_light` / `seg_en`. It sits downstream of the data-memory LED/IO register and replaces the display logic at the top level.

## Interface
- `SCAN_DIV`, 100000: clk cycles each digit stays lit.
  - 1 kHz digit rate at 100 MHz.
  - Minimum 32.
- `clk` input 1: system clock. All logic is posedge.
- `rst` input 1: reset, asynchronous, active-high.
- `value` input 16: number to display.
- `blank_en` input 1: 1 suppresses leading zeros. Digit 0 is never blanked.
- `dp` input 4: decimal point per digit. `dp[i]` lights digit i's point.
- `digital_light` output 8: segment drive, active-high.
  - Bit 7 = a, bit 6 = b, bit 5 = c, bit 4 = d, bit 3 = e, bit 2 = f, bit 1 = g, bit 0 = dp.
- `seg_en` output 4: digit enable, one-hot, active-high. `seg_en[0]` is the rightmost digit.

## Operation
- Divider `div_cnt` counts 0..SCAN_DIV-1.
  - At terminal count it returns to 0 and digit index `idx` advances 0→1→2→3→0.
- Frame start is `idx` wrapping to 0, or the first cycle after reset release. At frame start:
  - `value` is captured into `snap`.
  - Hex mode: `disp[15:0] <= snap` on the next cycle.
  - Decimal mode: converter starts on `snap`, then `disp` loads the 4 low BCD digits on completion.
  - If `snap` > 9999, `disp` is flagged overflow.
- `disp` holds its old contents until the update lands. `value` changes mid-frame are not visible until the next frame.
- Glyphs:
  - Digits 0-F use the standard hex shapes.
  - Overflow shows a dash (g only, 0x02) on all four digits. Leading-zero blanking is ignored during overflow.
  - A blanked digit outputs 0x00 except for its `dp` bit.
- Leading-zero blanking: a digit i ≥ 1 is blanked when it and all higher digits are 0.
- Output selection: `seg_en = 1<<idx`, and `digital_light = {glyph(disp digit idx), dp[idx]}`.

## Timing
- Reset values:
  - `digital_light` = 0x00 and `seg_en` = 4'b0000 (display dark).
  - `div_cnt`, `idx`, `snap`, `disp` and the converter are all 0 / idle.
- First cycle after reset release: `seg_en` = 4'b0001, and the snapshot is taken.
- `seg_en` and `digital_light` are registered. They change 1 cycle after the `idx` or `disp` change.
- Converter state machine:
  - States: IDLE → SHIFT (16 cycles, add-3 then shift, one bit per cycle) → DONE (1 cycle, loads `disp`) → IDLE.
  - Latency is 18 cycles from start to `disp` valid.
  - A start request while not IDLE is ignored. This cannot occur because SCAN_DIV ≥ 32.
- Decimal frame latency: digit 0 shows the stale `disp` for 19 cycles. This is invisible at the scan rate.
- `rst` asserted mid-frame or mid-conversion: the display blanks immediately and the converter aborts. Operation restarts from digit 0 with a fresh snapshot.
- `blank_en` and `dp` are sampled combinationally into the output register every cycle. They are not snapshotted.

## Configuration
- `SEG_DECIMAL_EN` defined:
  - The converter and overflow logic are compiled in.
  - The display is decimal 0-9999.
  - Overflow is shown for values 10000-65535.
- `SEG_DECIMAL_EN` undefined:
  - There is no converter and no overflow flag.
  - `disp` loads `snap` directly and the display is 4-digit hex.

## Structure
- The shared package `seg_pkg` holds:
  - digit count (4)
  - glyph constants for 0-F, DASH = 7'b0000001 and BLANK = 7'b0000000
  - converter state encoding (IDLE, SHIFT, DONE)
- One sub-module, `bin2bcd_seq`:
  - Ports: 16-bit in, start, done, 5×4-bit BCD out.
  - Uses the same `clk` / `rst`.
  - Instantiated only under `SEG_DECIMAL_EN`.

## Test plan
Benches run with SCAN_DIV=32.
1. Reset:
   - Hold `rst`: `seg_en` = 0000 and `digital_light` = 0x00.
   - Release: `seg_en` = 0001 and steps 0010, 0100, 1000 every 32 cycles, then wraps.
2. Hex (macro off), `value` = 16'h1A3F, `dp` = 0:
   - digit0 = 0x8E, digit1 = 0xF2, digit2 = 0xEE, digit3 = 0x60.
3. Decimal (macro on):
   - `value` = 1234 gives digit0 = 0x66, digit1 = 0xF2, digit2 = 0xDA, digit3 = 0x60, all within frame 1 after 18 cycles.
   - `value` = 12345 gives 0x02 on all digits.
4. Blanking, hex, `blank_en` = 1, `dp` = 4'b0100:
   - `value` = 0x0007 gives digit0 = 0xE0, digit1 = 0x00, digit2 = 0x01, digit3 = 0x00.
   - `value` = 0 gives digit0 = 0xFC.
5. Mid-frame change:
   - Change `value` from 0x1111 to 0x2222 while `idx` = 2.
   - Digits 2-3 still show 0x60. The next frame shows 0xDA on all digits.
6. Reset mid-conversion:
   - Assert `rst` 5 cycles after the decimal start.
   - Outputs go to 0 immediately. After release, the display shows the new `value` correctly.
